// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA sync monitor: the coordinate width,
// the lock FSM states and a saturating counter helper.
package vga_pkg;

   typedef logic [10:0] coord_t;

   typedef enum logic [1:0] {
      SEARCH,
      CHECK,
      LOCKED
   } lock_state_e;

   localparam coord_t CNT_MAX = 11'd2047;

   function automatic coord_t sat_inc(input coord_t v);
      return (v == CNT_MAX) ? v : v + 11'd1;
   endfunction

endpackage

// File: rtl/vga_edge_det.sv
// One-cycle registered copy of a sync input with fall/rise pulses.
// The delayed copy resets high so an input that is low out of reset reads as a fall.
module vga_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic fall,
   output logic rise
);

   logic dly;

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) dly <= 1'b1;
      else     dly <= din;
   end

   assign fall = dly & ~din;
   assign rise = ~dly & din;

endmodule

// File: rtl/vga_sync_monitor.sv
// Measures an active-low hs/vs stream, locks onto stable timing and regenerates
// active-region pixel coordinates with a data enable.
module vga_sync_monitor
   import vga_pkg::*;
#(
   parameter coord_t H_START     = 11'd113,
   parameter coord_t H_ACTIVE    = 11'd511,
   parameter coord_t V_START     = 11'd18,
   parameter coord_t V_ACTIVE    = 11'd383,
   parameter int     LOCK_FRAMES = 2
) (
   input  logic        clk_vga,
   input  logic        rst,
   input  logic        hs,
   input  logic        vs,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic        de,
   output logic        locked,
   output logic        frame_start,
   output logic [10:0] h_period,
   output logic [10:0] h_sync_w,
   output logic [10:0] v_lines,
   output logic [10:0] v_sync_w
);

   logic        hs_fall, hs_rise, vs_fall, vs_rise;
   coord_t      h_pos, v_pos, h_low, v_low;
   coord_t      ref_h_period, ref_v_lines;
   coord_t      h_meas, v_meas;
   logic        h_mis, frame_bad, timeout, snap;
   lock_state_e state, state_next;
   logic [7:0]  match_cnt, match_cnt_next;
   logic [11:0] h_end, v_end;
   logic        in_h, in_v, de_next;

   vga_edge_det u_hs_edge (.clk(clk_vga), .rst(rst), .din(hs), .fall(hs_fall), .rise(hs_rise));
   vga_edge_det u_vs_edge (.clk(clk_vga), .rst(rst), .din(vs), .fall(vs_fall), .rise(vs_rise));

   assign h_meas  = h_pos + 11'd1;
   assign v_meas  = v_pos + {10'd0, hs_fall};
   assign h_mis   = hs_fall && (h_meas != ref_h_period);
   assign timeout = (h_pos == CNT_MAX) || (v_pos == CNT_MAX);

   always_ff @(posedge clk_vga) begin
      if (rst) begin
         h_pos        <= '0;
         v_pos        <= '0;
         h_low        <= '0;
         v_low        <= '0;
         h_period     <= '0;
         h_sync_w     <= '0;
         v_lines      <= '0;
         v_sync_w     <= '0;
         frame_start  <= 1'b0;
         frame_bad    <= 1'b0;
         ref_h_period <= '0;
         ref_v_lines  <= '0;
      end else begin
         h_pos <= hs_fall ? '0 : sat_inc(h_pos);
         if (hs_fall) h_period <= h_meas;
         // The fall cycle itself is the first low clock, so the width starts at 1.
         if (hs_fall)  h_low <= 11'd1;
         else if (!hs) h_low <= sat_inc(h_low);
         if (hs_rise) h_sync_w <= h_low;

         if (vs_fall) begin
            v_lines <= v_meas;
            v_pos   <= '0;
         end else if (hs_fall) begin
            v_pos <= sat_inc(v_pos);
         end
         if (vs_fall)                v_low <= {10'd0, hs_fall};
         else if (hs_fall && !vs)    v_low <= sat_inc(v_low);
         if (vs_rise) v_sync_w <= v_low;

         frame_start <= vs_fall;
         if (vs_fall)    frame_bad <= 1'b0;
         else if (h_mis) frame_bad <= 1'b1;

         if (snap) begin
            ref_h_period <= hs_fall ? h_meas : h_period;
            ref_v_lines  <= v_meas;
         end
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_next     = state;
      match_cnt_next = match_cnt;
      snap           = 1'b0;
      if (timeout) begin
         state_next = SEARCH;
      end else begin
         case (state)
            SEARCH: if (vs_fall) begin
               state_next     = CHECK;
               snap           = 1'b1;
               match_cnt_next = 8'd1;
            end
            CHECK: if (vs_fall) begin
               if (frame_bad || h_mis || (v_meas != ref_v_lines)) begin
                  snap           = 1'b1;
                  match_cnt_next = 8'd1;
               end else if ((match_cnt + 8'd1) >= 8'(LOCK_FRAMES)) begin
                  state_next = LOCKED;
               end else begin
                  match_cnt_next = match_cnt + 8'd1;
               end
            end
            LOCKED: if (h_mis || (vs_fall && (v_meas != ref_v_lines))) state_next = SEARCH;
            default: state_next = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk_vga) begin
      if (rst) begin
         state     <= SEARCH;
         match_cnt <= '0;
         locked    <= 1'b0;
      end else begin
         state     <= state_next;
         match_cnt <= match_cnt_next;
         locked    <= (state_next == LOCKED);
      end
   end

   assign h_end   = {1'b0, H_START} + {1'b0, H_ACTIVE};
   assign v_end   = {1'b0, V_START} + {1'b0, V_ACTIVE};
   assign in_h    = (h_pos >= H_START) && ({1'b0, h_pos} < h_end);
   assign in_v    = (v_pos >= V_START) && ({1'b0, v_pos} < v_end);
   // Qualified with the next lock state so de drops in the same cycle as locked.
   assign de_next = (state_next == LOCKED) && in_h && in_v;

   always_ff @(posedge clk_vga) begin
      if (rst) begin
         de <= 1'b0;
         x  <= '0;
         y  <= '0;
      end else begin
         de <= de_next;
         x  <= de_next ? h_pos - H_START : '0;
         y  <= de_next ? v_pos - V_START : '0;
      end
   end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboarded bench for vga_sync_monitor: a default-parameter instance and a
// small-window instance watch the same reduced-size sync stream.
module tb_vga_sync_monitor;

   localparam int LINE    = 64;
   localparam int HSW     = 8;
   localparam int FRAME_L = 12;
   localparam int VSW     = 3;
   localparam int STRETCH = 73;
   localparam int HOLD    = 3000;

   typedef struct packed {
      logic        de;
      logic [10:0] x;
      logic [10:0] y;
   } exp_t;

   typedef struct packed {
      exp_t s;
      exp_t d;
   } pair_t;

   logic        clk_vga = 1'b0;
   logic        rst = 1'b1;
   logic        hs = 1'b1;
   logic        vs = 1'b1;

   logic [10:0] x_s, y_s, h_period_s, h_sync_w_s, v_lines_s, v_sync_w_s;
   logic        de_s, locked_s, frame_start_s;
   logic [10:0] x_d, y_d, h_period_d, h_sync_w_d, v_lines_d, v_sync_w_d;
   logic        de_d, locked_d, frame_start_d;

   pair_t sb[$];
   int    n_vec = 0;
   int    n_miss = 0;
   int    de_cnt = 0;
   logic  exp_lock = 1'b0;

   always #5 clk_vga = ~clk_vga;

   vga_sync_monitor #(
      .H_START(11'd10), .H_ACTIVE(11'd20), .V_START(11'd2), .V_ACTIVE(11'd5), .LOCK_FRAMES(2)
   ) dut_s (
      .clk_vga(clk_vga), .rst(rst), .hs(hs), .vs(vs),
      .x(x_s), .y(y_s), .de(de_s), .locked(locked_s), .frame_start(frame_start_s),
      .h_period(h_period_s), .h_sync_w(h_sync_w_s), .v_lines(v_lines_s), .v_sync_w(v_sync_w_s)
   );

   vga_sync_monitor dut_d (
      .clk_vga(clk_vga), .rst(rst), .hs(hs), .vs(vs),
      .x(x_d), .y(y_d), .de(de_d), .locked(locked_d), .frame_start(frame_start_d),
      .h_period(h_period_d), .h_sync_w(h_sync_w_d), .v_lines(v_lines_d), .v_sync_w(v_sync_w_d)
   );

   function automatic exp_t model(input logic lk, input int h, input int v,
                                  input int hst, input int hac, input int vst, input int vac);
      exp_t e = '0;
      if (lk && h >= hst && h < hst + hac && v >= vst && v < vst + vac) begin
         e.de = 1'b1;
         e.x  = 11'(h - hst);
         e.y  = 11'(v - vst);
      end
      return e;
   endfunction

   // One clock: drive inputs, compare outputs against the entry pushed one cycle
   // earlier, then push the expectation for the position the DUT holds now.
   task automatic step(input logic hs_v, input logic vs_v, input logic rst_v, input int h, input int v);
      pair_t e;
      @(posedge clk_vga);
      #1;
      hs  = hs_v;
      vs  = vs_v;
      rst = rst_v;
      @(negedge clk_vga);
      if (de_s === 1'b1) de_cnt++;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_vec += 2;
         if ({de_s, x_s, y_s} !== e.s) begin
            n_miss++;
            $display("FAIL coord_small t=%0t got de=%b x=%0d y=%0d want de=%b x=%0d y=%0d",
                     $time, de_s, x_s, y_s, e.s.de, e.s.x, e.s.y);
         end
         if ({de_d, x_d, y_d} !== e.d) begin
            n_miss++;
            $display("FAIL coord_default t=%0t got de=%b x=%0d y=%0d want de=%b x=%0d y=%0d",
                     $time, de_d, x_d, y_d, e.d.de, e.d.x, e.d.y);
         end
      end
      e.s = model(exp_lock, h, v, 10, 20, 2, 5);
      e.d = model(exp_lock, h, v, 113, 511, 18, 383);
      sb.push_back(e);
   endtask

   task automatic run_line(input int L, input int len, input int rst_at, input bit probe);
      for (int i = 0; i < len; i++) begin
         if (i == rst_at) exp_lock = 1'b0;
         step(i >= HSW, L >= VSW, i == rst_at, (i == 0) ? -1 : ((i - 1 > 2047) ? 2047 : i - 1), L);
         if (i == 1) begin
            n_vec += 2;
            if (locked_s !== exp_lock || locked_d !== exp_lock) begin
               n_miss++;
               $display("FAIL locked line=%0d t=%0t got s=%b d=%b want %b", L, $time, locked_s, locked_d, exp_lock);
            end
         end
         if (rst_at >= 0 && i == rst_at + 1) begin
            n_vec++;
            if ({locked_s, de_s, frame_start_s, x_s, y_s, h_period_s, h_sync_w_s, v_lines_s, v_sync_w_s,
                 locked_d, de_d, frame_start_d, x_d, y_d, h_period_d, h_sync_w_d, v_lines_d, v_sync_w_d} !== '0) begin
               n_miss++;
               $display("FAIL reset_mid_outputs t=%0t got locked=%b de=%b fs=%b hp=%0d hw=%0d vl=%0d vw=%0d want all 0",
                        $time, locked_s, de_s, frame_start_s, h_period_s, h_sync_w_s, v_lines_s, v_sync_w_s);
            end
         end
         if (probe && L == 0 && i < 3) begin
            n_vec++;
            if (frame_start_s !== (i == 1) || frame_start_d !== (i == 1)) begin
               n_miss++;
               $display("FAIL frame_start i=%0d got s=%b d=%b want %b", i, frame_start_s, frame_start_d, i == 1);
            end
            if (i == 1) begin
               n_vec++;
               if (v_lines_s !== 11'(FRAME_L) || v_lines_d !== 11'(FRAME_L)) begin
                  n_miss++;
                  $display("FAIL coincident_v_lines got s=%0d d=%0d want %0d", v_lines_s, v_lines_d, FRAME_L);
               end
            end
         end
      end
   endtask

   task automatic run_frame(input int stretch_at, input int hold_at, input int rst_line, input bit probe);
      for (int L = 0; L < FRAME_L; L++) begin
         int len;
         len = LINE;
         if (L == stretch_at) len = STRETCH;
         if (L == hold_at)    len = HSW + HOLD;
         run_line(L, len, (L == rst_line) ? 15 : -1, probe);
         if (L == stretch_at || L == hold_at) exp_lock = 1'b0;
      end
   endtask

   task automatic test_reset;
      exp_lock = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, -1, 0);
      n_vec++;
      if ({locked_s, de_s, frame_start_s, x_s, y_s, h_period_s, h_sync_w_s, v_lines_s, v_sync_w_s} !== '0) begin
         n_miss++;
         $display("FAIL reset_outputs got locked=%b de=%b fs=%b hp=%0d want all 0", locked_s, de_s, frame_start_s, h_period_s);
      end
   endtask

   task automatic test_nominal;
      run_frame(-1, -1, -1, 1'b0);
      run_frame(-1, -1, -1, 1'b0);
      n_vec++;
      if (locked_s !== 1'b0) begin
         n_miss++;
         $display("FAIL lock_before_third_vs got %b want 0", locked_s);
      end
      exp_lock = 1'b1;
      run_frame(-1, -1, -1, 1'b0);
      de_cnt = 0;
      run_frame(-1, -1, -1, 1'b0);
      n_vec++;
      if (de_cnt != 100) begin
         n_miss++;
         $display("FAIL de_cycles_per_frame got %0d want 100", de_cnt);
      end
      n_vec += 4;
      if (h_period_s !== 11'(LINE) || h_period_d !== 11'(LINE)) begin
         n_miss++;
         $display("FAIL h_period got s=%0d d=%0d want %0d", h_period_s, h_period_d, LINE);
      end
      if (h_sync_w_s !== 11'(HSW) || h_sync_w_d !== 11'(HSW)) begin
         n_miss++;
         $display("FAIL h_sync_w got s=%0d d=%0d want %0d", h_sync_w_s, h_sync_w_d, HSW);
      end
      if (v_lines_s !== 11'(FRAME_L) || v_lines_d !== 11'(FRAME_L)) begin
         n_miss++;
         $display("FAIL v_lines got s=%0d d=%0d want %0d", v_lines_s, v_lines_d, FRAME_L);
      end
      if (v_sync_w_s !== 11'(VSW) || v_sync_w_d !== 11'(VSW)) begin
         n_miss++;
         $display("FAIL v_sync_w got s=%0d d=%0d want %0d", v_sync_w_s, v_sync_w_d, VSW);
      end
   endtask

   task automatic test_coincident;
      run_frame(-1, -1, -1, 1'b1);
   endtask

   task automatic test_stretch;
      run_frame(4, -1, -1, 1'b0);
      run_frame(-1, -1, -1, 1'b0);
      exp_lock = 1'b1;
      run_frame(-1, -1, -1, 1'b0);
      run_frame(-1, -1, -1, 1'b0);
      n_vec++;
      if (locked_s !== 1'b1) begin
         n_miss++;
         $display("FAIL relock_after_stretch got %b want 1", locked_s);
      end
   endtask

   task automatic test_timeout;
      run_frame(-1, 5, -1, 1'b0);
      run_frame(-1, -1, -1, 1'b0);
      exp_lock = 1'b1;
      run_frame(-1, -1, -1, 1'b0);
      run_frame(-1, -1, -1, 1'b0);
      n_vec++;
      if (locked_s !== 1'b1 || locked_d !== 1'b1) begin
         n_miss++;
         $display("FAIL relock_after_timeout got s=%b d=%b want 1", locked_s, locked_d);
      end
   endtask

   task automatic test_reset_mid;
      run_frame(-1, -1, 4, 1'b0);
      run_frame(-1, -1, -1, 1'b0);
      run_frame(-1, -1, -1, 1'b0);
      exp_lock = 1'b1;
      run_frame(-1, -1, -1, 1'b0);
      n_vec++;
      if (locked_s !== 1'b1) begin
         n_miss++;
         $display("FAIL relock_after_reset got %b want 1", locked_s);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      test_reset();
      test_nominal();
      test_coincident();
      test_stretch();
      test_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
